// File: rtl/calc_if.sv
// Key buses from the keypad decoder and the result/status signals sent to the display stage.
interface calc_if #(
  parameter int W = 28
);
  logic [4:0]          numberKey;
  logic [4:0]          operatorKey;
  logic [4:0]          equalKey;
  logic [4:0]          clearKey;
  logic [4:0]          resetKey;
  logic signed [W-1:0] display;
  logic [1:0]          op_pending;
  logic                busy;
  logic                error;

  modport master (
    output numberKey, operatorKey, equalKey, clearKey, resetKey,
    input  display, op_pending, busy, error
  );

  modport slave (
    input  numberKey, operatorKey, equalKey, clearKey, resetKey,
    output display, op_pending, busy, error
  );
endinterface

// File: rtl/calc_controller.sv
// Keypad calculator sequencer: synchronizes and edge-detects key presses, builds decimal
// operands and runs add/sub or shift-add multiply on a shared accumulator.
module calc_controller #(
  parameter int DIGITS = 4,
  parameter int W      = 28
) (
  input  logic  newClock,
  input  logic  reset,
  calc_if.slave bus
);
  localparam int CW = $clog2(DIGITS + 1);
  localparam int MW = $clog2(W);
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_MUL  = 2'b11;

  typedef enum logic [2:0] {ENTER_A, ENTER_B, COMPUTE, DONE, ERROR} state_t;
  state_t state_q, state_d;

  logic [24:0]           raw, sync_p0, sync_p1;
  logic [4:0]            en_p1, en_prev_p1, rise;
  logic [4:0]            ev_p2;
  logic [3:0]            num_p2, opc_p2;
  logic                  ev_rst, ev_clr, ev_eq, ev_op, ev_num;
  logic [1:0]            op_dec;
  logic signed [W-1:0]   a_q, b_q, acc_q, disp_q;
  logic signed [W-1:0]   a_next, b_next, digit_w, mul_res, res;
  logic [1:0]            op_q;
  logic [CW-1:0]         cnt_q;
  logic [2*W-1:0]        mcand_q, prod_q, prod_nxt;
  logic [W-1:0]          mplier_q;
  logic [MW-1:0]         mul_cnt_q;
  logic                  mul_ovf_q, mul_ovf_nxt, neg_q, mul_last;
  logic                  done_now, res_ok, cnt_room;
  logic signed [W:0]     a_x, b_x, sum_x;
  logic                  unused_codes;

  function automatic logic [4:0] one_hot_prio(input logic [4:0] r);
    if (r[4])      return 5'b10000;
    else if (r[3]) return 5'b01000;
    else if (r[2]) return 5'b00100;
    else if (r[1]) return 5'b00010;
    else if (r[0]) return 5'b00001;
    else           return 5'b00000;
  endfunction

  function automatic logic [1:0] decode_op(input logic [3:0] c);
    case (c)
      4'hF:    return OP_ADD;
      4'hE:    return OP_SUB;
      4'hD:    return OP_MUL;
      default: return OP_NONE;
    endcase
  endfunction

  function automatic logic signed [W-1:0] append_digit(input logic signed [W-1:0] v,
                                                       input logic [3:0] d);
    return v * W'(10) + $signed({{(W-4){1'b0}}, d});
  endfunction

  function automatic logic [W-1:0] magnitude(input logic signed [W-1:0] v);
    return v[W-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic fits_w(input logic signed [W:0] v);
    return v[W] == v[W-1];
  endfunction

  assign raw = {bus.resetKey, bus.clearKey, bus.equalKey, bus.operatorKey, bus.numberKey};
  assign en_p1 = {sync_p1[24], sync_p1[19], sync_p1[14], sync_p1[9], sync_p1[4]};
  assign rise  = en_p1 & ~en_prev_p1;
  assign unused_codes = ^{sync_p1[23:20], sync_p1[18:15], sync_p1[13:10]};

  // Stage p0/p1: two-flop synchronizer; stage p2: rising-edge events, priority resolved
  always_ff @(posedge newClock) begin
    if (reset) begin
      sync_p0    <= '0;
      sync_p1    <= '0;
      en_prev_p1 <= '0;
      ev_p2      <= '0;
      num_p2     <= '0;
      opc_p2     <= '0;
    end else begin
      sync_p0    <= raw;
      sync_p1    <= sync_p0;
      en_prev_p1 <= en_p1;
      ev_p2      <= one_hot_prio(rise);
      num_p2     <= sync_p1[3:0];
      opc_p2     <= sync_p1[8:5];
    end
  end

  assign op_dec  = decode_op(opc_p2);
  assign ev_rst  = ev_p2[4];
  assign ev_clr  = ev_p2[3];
  assign ev_eq   = ev_p2[2];
  assign ev_op   = ev_p2[1] && (op_dec != OP_NONE);
  assign ev_num  = ev_p2[0] && (num_p2 <= 4'd9);
  assign digit_w = $signed({{(W-4){1'b0}}, num_p2});
  assign a_next  = append_digit(a_q, num_p2);
  assign b_next  = append_digit(b_q, num_p2);
  assign cnt_room = cnt_q < CW'(DIGITS);

  assign a_x   = {a_q[W-1], a_q};
  assign b_x   = {b_q[W-1], b_q};
  assign sum_x = (op_q == OP_SUB) ? a_x - b_x : a_x + b_x;

  // Magnitude shift-add: any partial sum reaching bit W-1 is an overflow
  assign prod_nxt    = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_ovf_nxt = mul_ovf_q | (|prod_nxt[2*W-1:W-1]);
  assign mul_last    = (mul_cnt_q == MW'(W-2));
  assign mul_res     = neg_q ? -$signed(prod_nxt[W-1:0]) : $signed(prod_nxt[W-1:0]);

  assign done_now = (op_q != OP_MUL) || mul_last;
  assign res      = (op_q == OP_MUL) ? mul_res : sum_x[W-1:0];
  assign res_ok   = (op_q == OP_MUL) ? !mul_ovf_nxt : fits_w(sum_x);

  always_ff @(posedge newClock) begin
    if (reset) state_q <= ENTER_A;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ev_rst) begin
      state_d = ENTER_A;
    end else begin
      case (state_q)
        ENTER_A: if (ev_op) state_d = ENTER_B;
        ENTER_B: if (ev_eq) state_d = COMPUTE;
        COMPUTE: if (done_now) state_d = res_ok ? DONE : ERROR;
        DONE: begin
          if (ev_clr || ev_num) state_d = ENTER_A;
          else if (ev_op)       state_d = ENTER_B;
        end
        ERROR:   state_d = ERROR;
        default: state_d = ENTER_A;
      endcase
    end
  end

  // Stage p3: operand entry and arithmetic; clearKey in DONE acts as all-clear
  always_ff @(posedge newClock) begin
    if (reset || ev_rst || (state_q == DONE && ev_clr)) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      op_q      <= OP_NONE;
      cnt_q     <= '0;
      disp_q    <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      mul_cnt_q <= '0;
      mul_ovf_q <= 1'b0;
      neg_q     <= 1'b0;
    end else begin
      case (state_q)
        ENTER_A: begin
          if (ev_clr) begin
            a_q    <= '0;
            cnt_q  <= '0;
            disp_q <= '0;
          end else if (ev_num && cnt_room) begin
            a_q    <= a_next;
            cnt_q  <= cnt_q + CW'(1);
            disp_q <= a_next;
          end else if (ev_op) begin
            op_q  <= op_dec;
            cnt_q <= '0;
            b_q   <= '0;
          end
        end
        ENTER_B: begin
          if (ev_clr) begin
            b_q    <= '0;
            cnt_q  <= '0;
            disp_q <= '0;
          end else if (ev_eq) begin
            mcand_q   <= {{W{1'b0}}, magnitude(a_q)};
            mplier_q  <= magnitude(b_q);
            prod_q    <= '0;
            mul_cnt_q <= '0;
            mul_ovf_q <= 1'b0;
            neg_q     <= a_q[W-1] ^ b_q[W-1];
          end else if (ev_op) begin
            if (cnt_q == '0) op_q <= op_dec;
          end else if (ev_num && cnt_room) begin
            b_q    <= b_next;
            cnt_q  <= cnt_q + CW'(1);
            disp_q <= b_next;
          end
        end
        COMPUTE: begin
          prod_q    <= prod_nxt;
          mcand_q   <= mcand_q << 1;
          mplier_q  <= mplier_q >> 1;
          mul_cnt_q <= mul_cnt_q + MW'(1);
          mul_ovf_q <= mul_ovf_nxt;
          if (done_now) begin
            if (res_ok) begin
              acc_q  <= res;
              a_q    <= res;
              disp_q <= res;
              op_q   <= OP_NONE;
              cnt_q  <= '0;
            end else begin
              disp_q <= '0;
            end
          end
        end
        DONE: begin
          if (ev_num) begin
            a_q    <= digit_w;
            cnt_q  <= CW'(1);
            disp_q <= digit_w;
          end else if (ev_op) begin
            op_q  <= op_dec;
            cnt_q <= '0;
            b_q   <= '0;
          end
        end
        ERROR:   disp_q <= '0;
        default: disp_q <= '0;
      endcase
    end
  end

  assign bus.display    = disp_q;
  assign bus.op_pending = op_q;
  assign bus.busy       = (state_q == COMPUTE);
  assign bus.error      = (state_q == ERROR);
endmodule

// File: tb/tb_calc_controller.sv
// Directed bench for calc_controller: key sequences with hand-computed display/status values.
module tb_calc_controller;
  localparam int W     = 28;
  localparam int K_NUM = 0;
  localparam int K_OP  = 1;
  localparam int K_EQ  = 2;
  localparam int K_CLR = 3;
  localparam int K_RST = 4;

  logic newClock = 1'b0;
  logic reset    = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   busy_cycles;

  calc_if #(.W(W)) kif();

  calc_controller #(.DIGITS(4), .W(W)) dut (
    .newClock(newClock),
    .reset   (reset),
    .bus     (kif)
  );

  always #5 newClock = ~newClock;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int k, input logic [3:0] c);
    case (k)
      K_NUM:   kif.numberKey   = {1'b1, c};
      K_OP:    kif.operatorKey = {1'b1, c};
      K_EQ:    kif.equalKey    = {1'b1, c};
      K_CLR:   kif.clearKey    = {1'b1, c};
      default: kif.resetKey    = {1'b1, c};
    endcase
  endtask

  task automatic release_all();
    kif.numberKey   = '0;
    kif.operatorKey = '0;
    kif.equalKey    = '0;
    kif.clearKey    = '0;
    kif.resetKey    = '0;
  endtask

  task automatic press(input int k, input logic [3:0] c);
    drive(k, c);
    repeat (4) @(negedge newClock);
    release_all();
    repeat (4) @(negedge newClock);
  endtask

  task automatic nines();
    for (int i = 0; i < 4; i++) press(K_NUM, 4'd9);
  endtask

  function automatic logic signed [63:0] disp();
    return $signed(kif.display);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    release_all();
    repeat (3) @(negedge newClock);
    reset = 1'b0;
    @(negedge newClock);
    check("rst_display", disp(), 0);
    check("rst_op", kif.op_pending, 0);
    check("rst_busy", kif.busy, 0);
    check("rst_error", kif.error, 0);

    // 12 + 34 = 46, then a digit in DONE starts a fresh calculation: 7 + 1 = 8
    press(K_NUM, 4'd1); press(K_NUM, 4'd2);
    check("t1_a12", disp(), 12);
    press(K_OP, 4'hF);
    check("t1_op_add", kif.op_pending, 1);
    check("t1_hold_a", disp(), 12);
    press(K_NUM, 4'd3); press(K_NUM, 4'd4);
    check("t1_b34", disp(), 34);
    press(K_EQ, 4'hB);
    check("t1_sum", disp(), 46);
    check("t1_op_clr", kif.op_pending, 0);
    check("t1_busy", kif.busy, 0);
    press(K_NUM, 4'd7);
    check("t1_new_a", disp(), 7);
    press(K_OP, 4'hF); press(K_NUM, 4'd1); press(K_EQ, 4'hB);
    check("t1_sum2", disp(), 8);

    // 7 - 9 = -2; operator replacement 2 F E 5 = -3
    press(K_RST, 4'hA);
    press(K_NUM, 4'd7); press(K_OP, 4'hE);
    check("t2_op_sub", kif.op_pending, 2);
    press(K_NUM, 4'd9); press(K_EQ, 4'hB);
    check("t2_diff", disp(), -2);
    check("t2_error", kif.error, 0);
    press(K_RST, 4'hA);
    press(K_NUM, 4'd2); press(K_OP, 4'hF); press(K_OP, 4'hE);
    check("t2_op_repl", kif.op_pending, 2);
    press(K_NUM, 4'd5); press(K_EQ, 4'hB);
    check("t2_diff2", disp(), -3);

    // 123 * 45 = 5535, busy for exactly W-1 cycles
    press(K_RST, 4'hA);
    press(K_NUM, 4'd1); press(K_NUM, 4'd2); press(K_NUM, 4'd3);
    press(K_OP, 4'hD);
    check("t3_op_mul", kif.op_pending, 3);
    press(K_NUM, 4'd4); press(K_NUM, 4'd5);
    busy_cycles = 0;
    drive(K_EQ, 4'hB);
    for (int i = 0; i < 60; i++) begin
      @(negedge newClock);
      if (i == 3) release_all();
      if (kif.busy) busy_cycles++;
    end
    check("t3_busy_cycles", busy_cycles, W - 1);
    check("t3_prod", disp(), 5535);
    check("t3_busy_end", kif.busy, 0);

    // digit limit, then same-cycle number+clear: clear wins
    press(K_RST, 4'hA);
    press(K_NUM, 4'd1); press(K_NUM, 4'd2); press(K_NUM, 4'd3); press(K_NUM, 4'd4);
    press(K_NUM, 4'd5);
    check("t4_limit", disp(), 1234);
    drive(K_NUM, 4'd7);
    drive(K_CLR, 4'hC);
    repeat (4) @(negedge newClock);
    release_all();
    repeat (4) @(negedge newClock);
    check("t4_clr_prio", disp(), 0);
    press(K_NUM, 4'd6);
    check("t4_after_clr", disp(), 6);

    // 9999*9999 fits; chaining another *9999 overflows into ERROR
    press(K_RST, 4'hA);
    nines(); press(K_OP, 4'hD); nines(); press(K_EQ, 4'hB);
    repeat (35) @(negedge newClock);
    check("t5_prod", disp(), 99980001);
    check("t5_no_err", kif.error, 0);
    press(K_OP, 4'hD);
    check("t5_chain_op", kif.op_pending, 3);
    check("t5_chain_hold", disp(), 99980001);
    nines(); press(K_EQ, 4'hB);
    repeat (35) @(negedge newClock);
    check("t5_err", kif.error, 1);
    check("t5_err_disp", disp(), 0);
    press(K_NUM, 4'd5);
    check("t5_digit_ign", disp(), 0);
    press(K_CLR, 4'hC);
    check("t5_clr_ign", kif.error, 1);
    press(K_RST, 4'hA);
    check("t5_rst_err", kif.error, 0);
    check("t5_rst_disp", disp(), 0);
    press(K_NUM, 4'd8);
    check("t5_enter_a", disp(), 8);

    // resetKey aborts COMPUTE; reset pin during ENTER_B
    press(K_RST, 4'hA);
    press(K_NUM, 4'd5); press(K_OP, 4'hD); press(K_NUM, 4'd6);
    drive(K_EQ, 4'hB);
    repeat (4) @(negedge newClock);
    check("t6_busy", kif.busy, 1);
    release_all();
    drive(K_RST, 4'hA);
    repeat (4) @(negedge newClock);
    check("t6_abort_busy", kif.busy, 0);
    check("t6_abort_disp", disp(), 0);
    check("t6_abort_op", kif.op_pending, 0);
    release_all();
    repeat (4) @(negedge newClock);
    press(K_NUM, 4'd3);
    check("t6_enter_a", disp(), 3);
    press(K_RST, 4'hA);
    press(K_NUM, 4'd1); press(K_OP, 4'hF); press(K_NUM, 4'd2);
    check("t6_b", disp(), 2);
    check("t6_op", kif.op_pending, 1);
    reset = 1'b1;
    @(negedge newClock);
    check("t6_rst_disp", disp(), 0);
    check("t6_rst_op", kif.op_pending, 0);
    check("t6_rst_busy", kif.busy, 0);
    check("t6_rst_err", kif.error, 0);
    reset = 1'b0;
    repeat (2) @(negedge newClock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
